fpadd_rr_sched: RTL
===================

// Module: fpadd_rr_sched
// PURPOSE
//  Round-robin scheduler that shares one fpadd instance among N_REQ requesters.
//  Accepts operand pairs, latches them and sequences fpadd start/done.
//  Routes each sum back to the requester that issued it.
//  A watchdog aborts a hung operation and pulses the adder's reset.
//  Sits between client FSMs (vector/accumulate units) and the single fpadd.
// PARAMETERS
//  N_REQ    4    number of requesters (2..8)
//  TIMEOUT  64   max cycles in WAIT before abort (>= 2)
// PORTS
//  clk        in   1         single clock, all logic posedge
//  reset      in   1         synchronous, active-high
//  req_valid  in   N_REQ     requester i has an operand pair pending
//  req_a      in   32*N_REQ  operand A, slice [32*i+:32]
//  req_b      in   32*N_REQ  operand B, slice [32*i+:32]
//  req_ready  out  N_REQ     one-hot 1-cycle pulse: pair from i accepted
//  rsp_valid  out  N_REQ     one-hot 1-cycle pulse: result for i on rsp_sum
//  rsp_sum    out  32        result word (IEEE-754 single)
//  rsp_err    out  1         qualifies rsp_valid: 1 = timed out, rsp_sum = 0
//  busy       out  1         high whenever state != IDLE
//  fp_start   out  1         to fpadd.start
//  fp_a       out  32        to fpadd.a; stable from ISSUE until RESP
//  fp_b       out  32        to fpadd.b; stable from ISSUE until RESP
//  fp_reset   out  1         to fpadd.reset = reset | abort pulse
//  fp_sum     in   32        from fpadd.sum
//  fp_done    in   1         from fpadd.done; may go high in the ISSUE cycle
// BEHAVIOUR
//  Reset: state=IDLE, ptr=N_REQ-1, all outputs 0 except fp_reset=1, op regs 0.
//  FSM (2-bit): IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE:
//    - If any req_valid, grant the first set bit searching ptr+1, ptr+2, ...
//      modulo N_REQ.
//    - Pulse req_ready[g]; latch req_a/req_b slices into op_a/op_b; owner=g;
//      ptr=g.
//    - Go to ISSUE. With no requests, stay in IDLE.
//   ISSUE:
//    - fp_start=1 for exactly this cycle.
//    - If fp_done=1 (special-case path of the adder), capture fp_sum and go
//      to RESP; else go to WAIT.
//    - Clear the watchdog counter.
//   WAIT:
//    - fp_start=0. Counter increments every cycle.
//    - On first fp_done=1: capture fp_sum into res, go to RESP.
//    - When counter reaches TIMEOUT-1 without done: res=0, err=1,
//      fp_reset=1 for one cycle, go to RESP.
//   RESP:
//    - rsp_valid[owner]=1, rsp_sum=res, rsp_err=err for one cycle.
//    - Go to IDLE; clear err.
//  Latency (done at cycle k after ISSUE):
//   - accept -> rsp_valid = k+2 cycles.
//   - Minimum 2 cycles when done fires in ISSUE.
//  Back-to-back throughput: one result per (k+3) cycles; no pipelining.
//  Handshake rules:
//   - A requester holds req_valid and its operands until its req_ready pulse.
//   - The scheduler never drops an accepted pair.
//   - Dropping req_valid before grant is legal and the request is simply
//     not served.
//  Fairness: a continuously requesting i waits at most N_REQ-1 other
//   operations.
//  Owner and ptr are log2 width (clog2(N_REQ)); wrap modulo N_REQ, including
//   non-power-of-2 N_REQ.
//  fp_done outside ISSUE/WAIT is ignored (no spurious rsp).
//  reset mid-operation:
//   - Returns to IDLE the next cycle.
//   - The in-flight result is discarded; no rsp_valid.
//   - ptr returns to N_REQ-1.
// STRUCTURE
//  Shared package fpadd_pkg: state encodings (S_IDLE..S_RESP), FP_W=32,
//   FP_ZERO constant.
//  One sub-module: rr_pick (N_REQ) -- combinational; inputs req, ptr;
//   outputs gnt_onehot, gnt_idx, any.
//  Top holds the FSM, op/res registers, watchdog counter and output decode.
// TESTING
//  1 Single requester: req0 a=3F800000 (1.0), b=40000000 (2.0); fpadd model
//    raises done 5 cycles after start -> rsp_valid=0001, rsp_sum=40400000,
//    rsp_err=0.
//  2 Zero shortcut: req2 a=00000000, b=C0A00000; done in ISSUE cycle ->
//    rsp_valid[2] 2 cycles after req_ready, rsp_sum=C0A00000.
//  3 Fairness: all four req_valid held high for 8 operations -> grant order
//    0,1,2,3,0,1,2,3; each rsp routed to matching index.
//  4 Timeout: model never raises done, TIMEOUT=64 -> fp_reset pulses once,
//    rsp_err=1, rsp_sum=0, busy falls.
//  5 Reset mid-WAIT: assert reset 3 cycles into WAIT -> no rsp_valid; IDLE
//    next cycle; the next request from 0 and 1 grants 0 first.
//  6 Stale done: pulse fp_done while IDLE -> no rsp_valid; state unchanged.

Source files
------------

// File: rtl/fpadd_pkg.sv
// Shared definitions for the fpadd round-robin scheduler: FSM encodings,
// word width and an index-width helper that tolerates a single-entry range.
package fpadd_pkg;

   localparam int FP_W = 32;
   localparam logic [FP_W-1:0] FP_ZERO = '0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fpadd_rr_sched_rr_pick.sv
// Combinational round-robin picker: grants the first requester strictly after
// ptr, wrapping modulo N_REQ (non-power-of-2 safe).
module rr_pick
   import fpadd_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int PW    = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [N_REQ-1:0] gnt_onehot,
   output logic [PW-1:0]    gnt_idx,
   output logic             any
);

   // NOTE: every output gets a default before the loops so no latch is inferred.
   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      any        = 1'b0;
      // Indices above ptr have priority, then the wrapped range 0..ptr.
      for (int i = 0; i < N_REQ; i++) begin
         if (!any && req[i] && (PW'(i) > ptr)) begin
            any           = 1'b1;
            gnt_idx       = PW'(i);
            gnt_onehot[i] = 1'b1;
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!any && req[i] && (PW'(i) <= ptr)) begin
            any           = 1'b1;
            gnt_idx       = PW'(i);
            gnt_onehot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fpadd_rr_sched.sv
// Round-robin scheduler sharing one fpadd among N_REQ requesters, with result
// routing back to the issuer and a watchdog that aborts and resets a hung adder.
module fpadd_rr_sched
   import fpadd_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [FP_W*N_REQ-1:0] req_a,
   input  logic [FP_W*N_REQ-1:0] req_b,
   output logic [N_REQ-1:0]      req_ready,
   output logic [N_REQ-1:0]      rsp_valid,
   output logic [FP_W-1:0]       rsp_sum,
   output logic                  rsp_err,
   output logic                  busy,
   output logic                  fp_start,
   output logic [FP_W-1:0]       fp_a,
   output logic [FP_W-1:0]       fp_b,
   output logic                  fp_reset,
   input  logic [FP_W-1:0]       fp_sum,
   input  logic                  fp_done
);

   localparam int PW = idx_w(N_REQ);
   localparam int CW = idx_w(TIMEOUT);
   localparam logic [PW-1:0] PTR_RST = PW'(N_REQ - 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

   state_t state, state_nxt;
   logic [PW-1:0]    ptr, owner;
   logic [FP_W-1:0]  op_a, op_b, res;
   logic             err;
   logic [CW-1:0]    cnt;
   logic [N_REQ-1:0] gnt_onehot;
   logic [PW-1:0]    gnt_idx;
   logic             gnt_any;
   logic             abort;
   logic [FP_W-1:0]  sel_a, sel_b;

   rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
      .req        (req_valid),
      .ptr        (ptr),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .any        (gnt_any)
   );

   // A done arriving in the last watchdog cycle still wins over the abort.
   assign abort = (state == S_WAIT) && !fp_done && (cnt == CNT_MAX);

   always_comb begin
      sel_a = FP_ZERO;
      sel_b = FP_ZERO;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_onehot[i]) begin
            sel_a = sel_a | req_a[i*FP_W +: FP_W];
            sel_b = sel_b | req_b[i*FP_W +: FP_W];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (gnt_any) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = fp_done ? S_RESP : S_WAIT;
         S_WAIT:  if (fp_done || abort) state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr   <= PTR_RST;
         owner <= '0;
         op_a  <= FP_ZERO;
         op_b  <= FP_ZERO;
         res   <= FP_ZERO;
         err   <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (gnt_any) begin
                  op_a  <= sel_a;
                  op_b  <= sel_b;
                  owner <= gnt_idx;
                  ptr   <= gnt_idx;
               end
            end
            S_ISSUE: begin
               cnt <= '0;
               if (fp_done) res <= fp_sum;
            end
            S_WAIT: begin
               cnt <= cnt + CW'(1);
               if (fp_done) begin
                  res <= fp_sum;
               end else if (abort) begin
                  res <= FP_ZERO;
                  err <= 1'b1;
               end
            end
            S_RESP:  err <= 1'b0;
            default: err <= 1'b0;
         endcase
      end
   end

   assign fp_a     = op_a;
   assign fp_b     = op_b;
   assign fp_reset = reset | abort;

   // Handshake outputs are held off during reset so nothing is accepted or delivered.
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      rsp_sum   = FP_ZERO;
      rsp_err   = 1'b0;
      fp_start  = 1'b0;
      busy      = !reset && (state != S_IDLE);
      if (!reset) begin
         case (state)
            S_IDLE:  req_ready = gnt_onehot;
            S_ISSUE: fp_start  = 1'b1;
            S_RESP: begin
               for (int i = 0; i < N_REQ; i++) rsp_valid[i] = (PW'(i) == owner);
               rsp_sum = res;
               rsp_err = err;
            end
            default: ;
         endcase
      end
   end

endmodule
